// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced key PIO with edge capture, IRQ mask and optional event FIFO (KEY_EVENT_FIFO_EN)
module key_event_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 8,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_s1, r_s2, r_h0, r_h1, r_deb, r_edge, r_mask;
    logic [31:0]      r_rdata, w_rdata, w_event_rd, w_status;
    logic             r_irq, w_tick, w_wr, w_rd, w_mask31, w_fifo_irq, w_unused;
    logic [WIDTH-1:0] w_stable, w_deb_next, w_change, w_press, w_edge_clr;
    assign w_tick     = r_pre == PW'(DEBOUNCE_CYCLES - 1);
    assign w_wr       = chipselect & write;
    assign w_rd       = chipselect & read;
    assign w_stable   = ~(r_s2 ^ r_h0) & ~(r_h0 ^ r_h1);
    assign w_deb_next = w_tick ? ((w_stable & r_s2) | (~w_stable & r_deb)) : r_deb;
    assign w_change   = w_deb_next ^ r_deb;
    assign w_press    = w_change & w_deb_next;
    assign w_edge_clr = (w_wr && address == 3'd2) ? writedata[WIDTH-1:0] : '0;
    assign w_unused   = ^writedata;
    assign readdata   = r_rdata;
    assign irq        = r_irq;
    // debounce sample prescaler, wraps every DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_pre <= '0;
        else r_pre <= w_tick ? '0 : r_pre + 1'b1;
    // synchroniser, sample history and debounced state (1 = pressed)
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_h0  <= '0;
            r_h1  <= '0;
            r_deb <= '0;
        end else begin
            r_s1  <= in_port ^ {WIDTH{ACTIVE_LOW}};
            r_s2  <= r_s1;
            r_h0  <= w_tick ? r_s2 : r_h0;
            r_h1  <= w_tick ? r_h0 : r_h1;
            r_deb <= w_deb_next;
        end
    // press edge capture (set beats clear) and edge mask
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_edge <= '0;
            r_mask <= '0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_press;
            r_mask <= (w_wr && address == 3'd1) ? writedata[WIDTH-1:0] : r_mask;
        end
`ifdef KEY_EVENT_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    typedef enum logic {S_IDLE, S_SCAN} state_t;
    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_pend, w_pend_next, w_clr_bit;
    logic [4:0]       w_k;
    logic             w_k_press, w_push, w_pop, w_full, w_accept, r_ovf, r_mask31;
    logic [5:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    assign w_pop      = w_rd && address == 3'd3 && r_cnt != '0;
    assign w_full     = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_mask31   = r_mask31;
    assign w_fifo_irq = r_mask31 & (r_cnt != '0);
    assign w_event_rd = (r_cnt != '0) ? {1'b1, 22'd0, r_mem[r_rp][5], 3'd0, r_mem[r_rp][4:0]} : '0;
    assign w_status   = {15'd0, r_ovf, 16'(r_cnt)};
    // lowest pending key and its current debounced level
    always_comb begin
        w_k       = '0;
        w_k_press = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (r_pend[i]) begin
                w_k       = 5'(i);
                w_k_press = r_deb[i];
            end
    end
    // scanner state register: state and pending-change set
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    // scanner next state: merge new changes, retire the scanned key
    always_comb begin
        w_pend_next  = (r_pend & ~w_clr_bit) | w_change;
        w_state_next = (w_pend_next != '0) ? S_SCAN : S_IDLE;
    end
    // scanner outputs: one event push per SCAN cycle
    always_comb begin
        w_push    = r_state == S_SCAN;
        w_clr_bit = w_push ? (WIDTH'(1) << w_k) : '0;
    end
    // event storage, written only on accepted pushes
    always_ff @(posedge clk)
        if (w_accept) r_mem[r_wp] <= {w_k_press, w_k};
    // FIFO pointers, count, sticky overflow and FIFO irq enable
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_mask31 <= 1'b0;
        end else begin
            r_wp     <= r_wp + AW'(w_accept);
            r_rp     <= r_rp + AW'(w_pop);
            r_cnt    <= r_cnt + (AW+1)'(w_accept) - (AW+1)'(w_pop);
            r_ovf    <= (r_ovf & ~(w_wr && address == 3'd4 && writedata[16])) | (w_push & ~w_accept);
            r_mask31 <= (w_wr && address == 3'd1) ? writedata[31] : r_mask31;
        end
`else
    assign w_mask31   = 1'b0;
    assign w_fifo_irq = 1'b0;
    assign w_event_rd = '0;
    assign w_status   = '0;
`endif
    // register read mux
    always_comb begin
        w_rdata = '0;
        case (address)
            3'd0:    w_rdata = 32'(r_deb);
            3'd1:    w_rdata = 32'(r_mask) | {w_mask31, 31'd0};
            3'd2:    w_rdata = 32'(r_edge);
            3'd3:    w_rdata = w_event_rd;
            3'd4:    w_rdata = w_status;
            default: w_rdata = '0;
        endcase
    end
    // registered read data and level interrupt
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_rdata <= w_rd ? w_rdata : r_rdata;
            r_irq   <= |(r_edge & r_mask) | w_fifo_irq;
        end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: randomized and directed checks of key_event_ctrl against a queue-based model
module tb_key_event_ctrl;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0, readdata;
    logic [7:0]  in_port = 8'hFF;
    logic        irq;
    int          checks = 0, fails = 0;
    logic [7:0]  m_deb = '0, m_edge = '0, m_mask = '0;
    logic        m_m31 = 1'b0, m_ovf = 1'b0;
    logic [31:0] q[$];
    logic [31:0] d;

    key_event_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(8), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        v = readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    function automatic logic exp_irq();
        logic f = 1'b0;
`ifdef KEY_EVENT_FIFO_EN
        f = m_m31 && q.size() != 0;
`endif
        return (|(m_edge & m_mask)) | f;
    endfunction

    task automatic check_irq(input string tag);
        repeat (2) @(negedge clk);
        check(tag, {31'd0, irq}, {31'd0, exp_irq()});
    endtask

    task automatic verify();
        logic [31:0] v;
        rd(3'd0, v); check("DATA", v, {24'd0, m_deb});
        rd(3'd2, v); check("EDGE", v, {24'd0, m_edge});
`ifdef KEY_EVENT_FIFO_EN
        rd(3'd1, v); check("IRQMASK", v, {m_m31, 23'd0, m_mask});
        rd(3'd4, v); check("STATUS", v, {15'd0, m_ovf, 16'(q.size())});
`else
        rd(3'd1, v); check("IRQMASK", v, {24'd0, m_mask});
`endif
        check_irq("irq");
    endtask

    // a debounced change of all keys to pattern p (1 = pressed)
    task automatic apply(input logic [7:0] p);
        logic [7:0] ch;
        ch = p ^ m_deb;
        in_port = ~p;
        m_edge |= ch & p;
`ifdef KEY_EVENT_FIFO_EN
        for (int k = 0; k < 8; k++)
            if (ch[k]) begin
                if (q.size() < 8) q.push_back(32'h8000_0000 | (32'(p[k]) << 8) | 32'(k));
                else m_ovf = 1'b1;
            end
`endif
        m_deb = p;
        repeat (40) @(negedge clk);
        verify();
    endtask

    // a one-sample-period disturbance that must not change debounced state
    task automatic glitch(input logic [7:0] g);
        logic [31:0] v;
        in_port = ~(m_deb ^ g);
        repeat (4) @(negedge clk);
        in_port = ~m_deb;
        repeat (16) @(negedge clk);
        rd(3'd0, v); check("glitch DATA", v, {24'd0, m_deb});
        rd(3'd2, v); check("glitch EDGE", v, {24'd0, m_edge});
    endtask

    task automatic pop_n(input int n);
        logic [31:0] v, e;
        for (int i = 0; i < n; i++) begin
            rd(3'd3, v);
            e = (q.size() != 0) ? q.pop_front() : 32'd0;
            check("EVENT", v, e);
        end
        check_irq("irq after pop");
    endtask

    task automatic clear_edge(input logic [7:0] c);
        wr(3'd2, {24'd0, c});
        m_edge &= ~c;
        check_irq("irq after EDGE clear");
    endtask

    task automatic set_mask(input logic [31:0] v);
        wr(3'd1, v);
        m_mask = v[7:0];
`ifdef KEY_EVENT_FIFO_EN
        m_m31 = v[31];
`endif
        check_irq("irq after mask");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset readdata", readdata, 32'd0);
        check("reset irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset readdata", readdata, 32'd0);
        check("post-reset irq", {31'd0, irq}, 32'd0);
        verify();
        apply(8'h01);
        glitch(8'h02);
        set_mask(32'h0000_0001);
        clear_edge(8'h01);
        wr(3'd5, 32'hFFFF_FFFF);
        for (int a = 5; a < 8; a++) begin
            rd(3'(a), d); check("unused addr", d, 32'd0);
        end
`ifdef KEY_EVENT_FIFO_EN
        pop_n(q.size() + 1);
        apply(8'h25);
        pop_n(3);
        apply(8'hDA);
        apply(8'hDB);
        wr(3'd4, 32'h0001_0000);
        m_ovf = 1'b0;
        verify();
        pop_n(9);
        set_mask(32'h8000_0000);
        apply(8'hDF);
        pop_n(2);
`else
        set_mask(32'h8000_0000);
        apply(8'hDA);
        rd(3'd3, d); check("no-FIFO EVENT", d, 32'd0);
        rd(3'd4, d); check("no-FIFO STATUS", d, 32'd0);
`endif
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 2) == 0) glitch(8'($urandom));
            apply(8'($urandom));
`ifdef KEY_EVENT_FIFO_EN
            pop_n($urandom_range(0, q.size() + 1));
`endif
            clear_edge(8'($urandom));
            set_mask($urandom);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
